// File: rtl/img_bbox_detect.sv
// Colour-threshold bounding-box detector. Passes the video stream through
// with one register stage. Active pixels whose R, G and B channels all fall
// inside their windows are recorded, and the min/max column and row of the
// matching pixels are tracked across the frame. At each vsync rising edge
// the box of the frame just finished is published, and it holds for the
// whole following frame.
module img_bbox_detect #(
    parameter logic [7:0]  R_MIN    = 8'd200,
    parameter logic [7:0]  R_MAX    = 8'd255,
    parameter logic [7:0]  G_MIN    = 8'd0,
    parameter logic [7:0]  G_MAX    = 8'd60,
    parameter logic [7:0]  B_MIN    = 8'd200,
    parameter logic [7:0]  B_MAX    = 8'd255,
    parameter logic [19:0] MIN_HITS = 20'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_i,
    input  logic        hs_i,
    input  logic        de_i,
    input  logic [23:0] data_i,
    output logic        vs_o,
    output logic        hs_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic [10:0] rect_x1,
    output logic [10:0] rect_y1,
    output logic [10:0] rect_x2,
    output logic [10:0] rect_y2,
    output logic        rect_valid,
    output logic        frame_done
);

    // IDLE: no complete frame has been seen since reset. RUN: armed to publish.
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [10:0] COORD_MAX = 11'h7FF;
    localparam logic [19:0] HITS_MAX  = 20'hFFFFF;

    state_t      state_q, state_d;
    logic        vs_q, hs_q, de_q;
    logic [23:0] data_q;
    logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [10:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [10:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [19:0] hit_cnt_q, hit_cnt_d;
    logic        found_q, found_d;
    logic [10:0] rect_x1_q, rect_x1_d, rect_y1_q, rect_y1_d;
    logic [10:0] rect_x2_q, rect_x2_d, rect_y2_q, rect_y2_d;
    logic        rect_valid_q, rect_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        vs_rise, de_fall, pix_hit;

    // Inclusive window test done with a borrow bit, so a window edge at 0 or
    // 255 does not turn into a constant comparison.
    function automatic logic in_range(input logic [7:0] ch, input logic [7:0] lo,
                                      input logic [7:0] hi);
        logic [8:0] d_lo;
        logic [8:0] d_hi;
        d_lo = {1'b0, ch} - {1'b0, lo};
        d_hi = {1'b0, hi} - {1'b0, ch};
        return ~d_lo[8] & ~d_hi[8];
    endfunction

    // Edge detection, pixel classification and next-state of all counters.
    always_comb begin
        vs_rise = vs_i & ~vs_q;
        de_fall = ~de_i & de_q;
        // A pixel arriving on the vsync edge belongs to neither frame.
        pix_hit = de_i & ~vs_rise
                & in_range(data_i[23:16], R_MIN, R_MAX)
                & in_range(data_i[15:8],  G_MIN, G_MAX)
                & in_range(data_i[7:0],   B_MIN, B_MAX);

        state_d      = state_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        min_x_d      = min_x_q;
        max_x_d      = max_x_q;
        min_y_d      = min_y_q;
        max_y_d      = max_y_q;
        hit_cnt_d    = hit_cnt_q;
        found_d      = found_q;
        rect_x1_d    = rect_x1_q;
        rect_y1_d    = rect_y1_q;
        rect_x2_d    = rect_x2_q;
        rect_y2_d    = rect_y2_q;
        rect_valid_d = rect_valid_q;
        frame_done_d = 1'b0;

        // Column counter: position of the current pixel, saturating at 2047.
        if (vs_rise || de_fall)
            x_cnt_d = '0;
        else if (de_i && x_cnt_q != COORD_MAX)
            x_cnt_d = x_cnt_q + 11'd1;

        // Row counter advances at the end of each active line.
        if (vs_rise)
            y_cnt_d = '0;
        else if (de_fall && y_cnt_q != COORD_MAX)
            y_cnt_d = y_cnt_q + 11'd1;

        if (pix_hit) begin
            if (x_cnt_q < min_x_q) min_x_d = x_cnt_q;
            if (x_cnt_q > max_x_q) max_x_d = x_cnt_q;
            if (y_cnt_q < min_y_q) min_y_d = y_cnt_q;
            if (y_cnt_q > max_y_q) max_y_d = y_cnt_q;
            if (hit_cnt_q != HITS_MAX) hit_cnt_d = hit_cnt_q + 20'd1;
            found_d = 1'b1;
        end

        if (vs_rise) begin
            // The first frame after reset may be partial, so it is only used
            // to arm the publisher.
            if (state_q == ST_RUN) begin
                frame_done_d = 1'b1;
                if (found_q && hit_cnt_q >= MIN_HITS) begin
                    rect_x1_d    = min_x_q;
                    rect_y1_d    = min_y_q;
                    rect_x2_d    = max_x_q;
                    rect_y2_d    = max_y_q;
                    rect_valid_d = 1'b1;
                end else begin
                    rect_x1_d    = '0;
                    rect_y1_d    = '0;
                    rect_x2_d    = '0;
                    rect_y2_d    = '0;
                    rect_valid_d = 1'b0;
                end
            end
            state_d   = ST_RUN;
            min_x_d   = COORD_MAX;
            max_x_d   = '0;
            min_y_d   = COORD_MAX;
            max_y_d   = '0;
            hit_cnt_d = '0;
            found_d   = 1'b0;
        end
    end

    // State, pass-through and accumulator registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            de_q         <= 1'b0;
            data_q       <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            min_x_q      <= COORD_MAX;
            max_x_q      <= '0;
            min_y_q      <= COORD_MAX;
            max_y_q      <= '0;
            hit_cnt_q    <= '0;
            found_q      <= 1'b0;
            rect_x1_q    <= '0;
            rect_y1_q    <= '0;
            rect_x2_q    <= '0;
            rect_y2_q    <= '0;
            rect_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_i;
            hs_q         <= hs_i;
            de_q         <= de_i;
            data_q       <= data_i;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            min_x_q      <= min_x_d;
            max_x_q      <= max_x_d;
            min_y_q      <= min_y_d;
            max_y_q      <= max_y_d;
            hit_cnt_q    <= hit_cnt_d;
            found_q      <= found_d;
            rect_x1_q    <= rect_x1_d;
            rect_y1_q    <= rect_y1_d;
            rect_x2_q    <= rect_x2_d;
            rect_y2_q    <= rect_y2_d;
            rect_valid_q <= rect_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign vs_o       = vs_q;
    assign hs_o       = hs_q;
    assign de_o       = de_q;
    assign data_o     = data_q;
    assign rect_x1    = rect_x1_q;
    assign rect_y1    = rect_y1_q;
    assign rect_x2    = rect_x2_q;
    assign rect_y2    = rect_y2_q;
    assign rect_valid = rect_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_img_bbox_detect.sv
// Directed bench for img_bbox_detect. Two instances share the input stream:
// dut_a with the default hit threshold of 16, dut_b with a threshold of 1.
module tb_img_bbox_detect;

    localparam logic [23:0] HIT  = 24'hFF00FF;
    localparam logic [23:0] EDGE = 24'hC83CC8;  // R=200, G=60, B=200: inclusive limits

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs_i, hs_i, de_i;
    logic [23:0] data_i;

    logic        vs_o_a, hs_o_a, de_o_a, rect_valid_a, frame_done_a;
    logic [23:0] data_o_a;
    logic [10:0] rect_x1_a, rect_y1_a, rect_x2_a, rect_y2_a;
    logic        vs_o_b, hs_o_b, de_o_b, rect_valid_b, frame_done_b;
    logic [23:0] data_o_b;
    logic [10:0] rect_x1_b, rect_y1_b, rect_x2_b, rect_y2_b;

    logic [44:0] box_a, box_b;
    assign box_a = {rect_valid_a, rect_x1_a, rect_y1_a, rect_x2_a, rect_y2_a};
    assign box_b = {rect_valid_b, rect_x1_b, rect_y1_b, rect_x2_b, rect_y2_b};

    int passes = 0;
    int fails  = 0;
    int checks = 0;

    img_bbox_detect dut_a (
        .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i), .data_i(data_i),
        .vs_o(vs_o_a), .hs_o(hs_o_a), .de_o(de_o_a), .data_o(data_o_a),
        .rect_x1(rect_x1_a), .rect_y1(rect_y1_a), .rect_x2(rect_x2_a), .rect_y2(rect_y2_a),
        .rect_valid(rect_valid_a), .frame_done(frame_done_a)
    );

    img_bbox_detect #(.MIN_HITS(20'd1)) dut_b (
        .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i), .data_i(data_i),
        .vs_o(vs_o_b), .hs_o(hs_o_b), .de_o(de_o_b), .data_o(data_o_b),
        .rect_x1(rect_x1_b), .rect_y1(rect_y1_b), .rect_x2(rect_x2_b), .rect_y2(rect_y2_b),
        .rect_valid(rect_valid_b), .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] bx(input logic v, input int x1, input int y1,
                                       input int x2, input int y2);
        return {v, 11'(x1), 11'(y1), 11'(x2), 11'(y2)};
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One active line of len pixels; columns hs..he get colour col, others bg.
    task automatic send_line(input int len, input int hs, input int he,
                             input logic [23:0] col, input logic [23:0] bg);
        for (int i = 0; i < len; i++) begin
            de_i   = 1'b1;
            data_i = (i >= hs && i <= he) ? col : bg;
            tick();
        end
        de_i   = 1'b0;
        data_i = 24'h0;
        tick();
    endtask

    // Two-cycle vsync pulse; checks the frame_done pulse of both instances.
    task automatic vsync(input string tag, input logic [1:0] exp_fd);
        vs_i = 1'b1;
        tick();
        chk({tag, "_fd"}, 64'({frame_done_a, frame_done_b}), 64'(exp_fd));
        tick();
        chk({tag, "_fd_width"}, 64'({frame_done_a, frame_done_b}), 64'd0);
        vs_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [26:0] prev_in;

        // Reset with activity on the inputs: outputs must stay zero.
        rst_n = 1'b0; vs_i = 1'b0; hs_i = 1'b1; de_i = 1'b1; data_i = HIT;
        tick(); tick(); tick();
        chk("rst_pass", 64'({vs_o_a, hs_o_a, de_o_a, data_o_a}), 64'd0);
        chk("rst_box", 64'(box_a), 64'd0);
        chk("rst_fd", 64'({frame_done_a, frame_done_b}), 64'd0);
        hs_i = 1'b0; de_i = 1'b0; data_i = 24'h0;
        tick();
        rst_n = 1'b1;

        // Partial frame with hits before the first vsync is discarded.
        send_line(20, 0, 19, HIT, 24'h0);
        vsync("arm", 2'b00);
        chk("arm_box_a", 64'(box_a), 64'd0);
        chk("arm_box_b", 64'(box_b), 64'd0);

        // Box at x 100..199, y 50..79.
        for (int y = 0; y < 85; y++) begin
            if (y >= 50 && y <= 79) send_line(210, 100, 199, HIT, 24'h0);
            else                    send_line(210, 1, 0, HIT, 24'h0);
        end
        vsync("box", 2'b11);
        chk("box_a", 64'(box_a), 64'(bx(1'b1, 100, 50, 199, 79)));
        chk("box_b", 64'(box_b), 64'(bx(1'b1, 100, 50, 199, 79)));

        // Frame of near-miss colours: each misses exactly one window by 1.
        for (int y = 0; y < 10; y++) begin
            if (y == 5) chk("box_hold", 64'(box_a), 64'(bx(1'b1, 100, 50, 199, 79)));
            case (y % 3)
                0:       send_line(30, 1, 0, HIT, 24'hC700FF);
                1:       send_line(30, 1, 0, HIT, 24'hFF3DFF);
                default: send_line(30, 1, 0, HIT, 24'hFF00C7);
            endcase
        end
        vsync("nohit", 2'b11);
        chk("nohit_a", 64'(box_a), 64'd0);
        chk("nohit_b", 64'(box_b), 64'd0);

        // Three hits: below the default threshold, above dut_b's.
        for (int y = 0; y < 5; y++) begin
            if (y == 2) send_line(20, 5, 7, HIT, 24'h0);
            else        send_line(20, 1, 0, HIT, 24'h0);
        end
        vsync("few", 2'b11);
        chk("few_a", 64'(box_a), 64'd0);
        chk("few_b", 64'(box_b), 64'(bx(1'b1, 5, 2, 7, 2)));

        // Exactly 16 hits using the inclusive channel limits.
        for (int y = 0; y < 5; y++) begin
            if (y == 3) send_line(30, 4, 19, EDGE, 24'h0);
            else        send_line(30, 1, 0, HIT, 24'h0);
        end
        vsync("sixteen", 2'b11);
        chk("sixteen_a", 64'(box_a), 64'(bx(1'b1, 4, 3, 19, 3)));
        chk("sixteen_b", 64'(box_b), 64'(bx(1'b1, 4, 3, 19, 3)));

        // Asynchronous reset mid-line, between clock edges.
        de_i = 1'b1; data_i = HIT;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pass", 64'({vs_o_a, hs_o_a, de_o_a, data_o_a}), 64'd0);
        chk("arst_box", 64'(box_a), 64'd0);
        de_i = 1'b0; data_i = 24'h0;
        tick();
        rst_n = 1'b1;
        send_line(30, 0, 29, HIT, 24'h0);
        vsync("rearm", 2'b00);
        chk("rearm_box_b", 64'(box_b), 64'd0);

        // Corner hits at (0,0) and (639,479).
        send_line(1, 0, 0, HIT, 24'h0);
        for (int y = 1; y < 479; y++) send_line(1, 1, 0, HIT, 24'h0);
        send_line(640, 639, 639, HIT, 24'h0);
        vsync("corner", 2'b11);
        chk("corner_a", 64'(box_a), 64'd0);
        chk("corner_b", 64'(box_b), 64'(bx(1'b1, 0, 0, 639, 479)));

        // Single hit at (320,240).
        for (int y = 0; y < 240; y++) send_line(1, 1, 0, HIT, 24'h0);
        send_line(321, 320, 320, HIT, 24'h0);
        vsync("single", 2'b11);
        chk("single_b", 64'(box_b), 64'(bx(1'b1, 320, 240, 320, 240)));

        // Hit beyond column 2047 clamps; then vsync rises on a hit pixel.
        send_line(2100, 2099, 2099, HIT, 24'h0);
        vs_i = 1'b1; de_i = 1'b1; data_i = HIT;
        tick();
        chk("clamp_fd", 64'({frame_done_a, frame_done_b}), 64'd3);
        chk("clamp_b", 64'(box_b), 64'(bx(1'b1, 2047, 0, 2047, 0)));
        data_i = 24'h0;
        tick();
        vs_i = 1'b0; data_i = HIT;
        tick();
        de_i = 1'b0; data_i = 24'h0;
        tick();
        vsync("vsde", 2'b11);
        chk("vsde_b", 64'(box_b), 64'(bx(1'b1, 1, 0, 1, 0)));

        // Pass-through: each output equals the input one cycle earlier.
        for (int i = 0; i < 24; i++) begin
            {vs_i, hs_i, de_i} = 3'($urandom);
            data_i = 24'($urandom);
            prev_in = {vs_i, hs_i, de_i, data_i};
            tick();
            chk("pass", 64'({vs_o_a, hs_o_a, de_o_a, data_o_a}), 64'(prev_in));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/img_bbox_detect.md
Name: img_bbox_detect

Overview:
- Colour-threshold bounding-box detector placed directly upstream of the rectangle-overlay stage in the image processing pipeline.
- Passes the video stream through with a 1-cycle register delay.
- Classifies each active pixel against per-channel RGB windows and tracks min/max x/y of matching pixels across a frame.
- At each frame boundary, publishes the box as rect_x1/y1/x2/y2 plus a valid flag; these drive the overlay stage's rectangle coordinate inputs on the next frame.

Parameters:
- R_MIN, 8'd200, lower bound of red channel (data_i[23:16]) for a hit
- R_MAX, 8'd255, upper bound of red channel
- G_MIN, 8'd0, lower bound of green channel (data_i[15:8])
- G_MAX, 8'd60, upper bound of green channel
- B_MIN, 8'd200, lower bound of blue channel (data_i[7:0])
- B_MAX, 8'd255, upper bound of blue channel
- MIN_HITS, 20'd16, minimum hit-pixel count per frame for the box to be published as valid

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- vs_i  input  1  vertical sync, active high; rising edge marks frame boundary
- hs_i  input  1  horizontal sync, passed through only
- de_i  input  1  data enable, high during active pixels
- data_i  input  24  RGB888 pixel {R,G,B}
- vs_o  output  1  vs_i delayed 1 cycle
- hs_o  output  1  hs_i delayed 1 cycle
- de_o  output  1  de_i delayed 1 cycle
- data_o  output  24  data_i delayed 1 cycle
- rect_x1  output  11  left column of last published box
- rect_y1  output  11  top row
- rect_x2  output  11  right column, inclusive
- rect_y2  output  11  bottom row, inclusive
- rect_valid  output  1  high while published box meets MIN_HITS
- frame_done  output  1  1-cycle pulse at each publish event

Behaviour:
- Reset: one clock, clk; rst_n is asynchronous active-low. On reset, all outputs = 0, all counters/accumulators = 0, armed = 0.
- Pass-through: vs_o/hs_o/de_o/data_o are registered copies of the inputs, latency exactly 1 cycle, no modification.
- Edge detection: vs_i and de_i are each registered once. vs_rise = vs_i & ~vs_d. de_fall = ~de_i & de_d.
- x_cnt (11b): increments on every de_i=1 cycle and saturates at 2047; the value used for a pixel is x_cnt before increment (first pixel of a line = 0). Cleared on de_fall.
- y_cnt (11b): increments on de_fall and saturates at 2047. Cleared on vs_rise.
- Hit: de_i=1 and every channel is within its [MIN,MAX] range, inclusive.
- On a hit:
  - min_x = min(min_x,x); max_x = max(max_x,x); same for y.
  - hit_cnt (20b, saturating) increments.
  - found set on first hit.
  - Accumulator init values: min = 11'h7FF, max = 0.
- On vs_rise, state transitions IDLE -> RUN:
  - If armed=0: only clear accumulators, then set armed=1; no publish and no frame_done. This discards the partial frame after reset.
  - If armed=1:
    - frame_done=1 for 1 cycle.
    - If found and hit_cnt >= MIN_HITS: rect_* <= accumulated min/max and rect_valid <= 1.
    - Otherwise: rect_* <= 0 and rect_valid <= 0.
    - Accumulators, hit_cnt and found are then cleared.
- rect_* and rect_valid are stable for the whole following frame and change only on the vs_rise publish cycle or on reset.
- vs_rise coincident with de_i=1 (illegal timing): vs_rise takes priority; that pixel is not accumulated; x_cnt is cleared.
- Reset mid-frame: immediate clear; the next frame is discarded via the armed rule.
- Hit pixels beyond column/row 2047 clamp to 2047.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 asynchronously. Release, then run one vs pulse -> frame_done stays 0 and rect_valid stays 0.
- Pass-through: random vs/hs/de/data -> each output equals its input from 1 cycle earlier, bit-exact.
- Box detect: 640x480 frames, pixels 24'hFF00FF at x 100..199, y 50..79, 24'h000000 elsewhere -> at the second post-reset vs_rise, frame_done pulses 1 cycle and rect = (100,50,199,79), rect_valid=1. Values hold through the next frame.
- No hits: all-black frame following a valid frame -> frame_done pulses, rect = (0,0,0,0), rect_valid=0.
- Below threshold: 3 hit pixels with MIN_HITS=16 -> rect_valid=0, rect = 0. With 16 hit pixels -> rect_valid=1.
- Corners: MIN_HITS=1, hits only at (0,0) and (639,479) -> rect = (0,0,639,479), rect_valid=1. Single hit at (320,240) -> rect = (320,240,320,240).
